// File: rtl/quant_h264_pkg.sv
// Shared constants and helpers for the H.264 4x4 forward quantizer and dequantizer.
// Holds the MF scaling table, the QP clamp limit, the position-class type and the rounding-offset helper.
// Pure definitions: no timing and no flow control of its own.
package quant_h264_pkg;

  localparam int COEF_W_DEF  = 13;
  localparam int LEVEL_W_DEF = 12;
  localparam int MF_W        = 14;   // largest MF (13107) needs 14 bits
  localparam int F_W         = 28;   // rounding offset width, matches the sum width
  localparam int QP_MAX      = 51;

  // Position class of a coefficient inside the 4x4 block
  typedef enum logic [1:0] {
    CLS_A    = 2'd0,   // row and column both even
    CLS_B    = 2'd1,   // row and column both odd
    CLS_C    = 2'd2,   // mixed parity
    CLS_RSVD = 2'd3
  } pos_cls_t;

  // MF[qp%6][class]
  localparam logic [MF_W-1:0] MF_TAB [0:5][0:2] = '{
    '{14'd13107, 14'd5243, 14'd8066},
    '{14'd11916, 14'd4660, 14'd7490},
    '{14'd10082, 14'd4194, 14'd6554},
    '{14'd9362,  14'd3647, 14'd5825},
    '{14'd8192,  14'd3355, 14'd5243},
    '{14'd7282,  14'd2893, 14'd4559}
  };

  // idx = row*4 + col, so row parity is idx[2] and column parity is idx[0]
  function automatic pos_cls_t pos_class(input logic [3:0] idx);
    if (!idx[2] && !idx[0]) begin
      return CLS_A;
    end else if (idx[2] && idx[0]) begin
      return CLS_B;
    end else begin
      return CLS_C;
    end
  endfunction

  // Deadzone offset: 2^qbits/3 for intra, 2^qbits/6 for inter (both floored)
  function automatic logic [F_W-1:0] round_f(input logic [4:0] qbits, input logic intra);
    logic [F_W-1:0] p;
    p = F_W'(1) << qbits;
    return intra ? (p / F_W'(3)) : (p / F_W'(6));
  endfunction

endpackage

// File: rtl/quant_mf_lut.sv
// MF lookup: (qp%6, position class) -> quantizer multiplication factor.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module quant_mf_lut
  import quant_h264_pkg::*;
(
  input  logic [2:0]      qp_mod6,
  input  pos_cls_t        cls,
  output logic [MF_W-1:0] mf
);

  // Table read; out-of-range selectors give zero rather than X
  always_comb begin
    mf = '0;
    if (qp_mod6 <= 3'd5 && cls != CLS_RSVD) begin
      mf = MF_TAB[qp_mod6][cls];
    end
  end

endmodule

// File: rtl/quant4x4_h264.sv
// H.264 4x4 forward quantizer: one coefficient per cycle through a 2-stage multiply/round pipeline.
// Latency: accept at edge T, last level written at T+17, out_valid high for the cycle after T+17, in_ready back at T+18.
// Backpressure: in_ready only in IDLE; in_valid while busy is dropped and sets sticky overrun. QUANT_NZ_COUNT_EN adds nz_count.
module quant4x4_h264
  import quant_h264_pkg::*;
#(
  parameter int COEF_W  = COEF_W_DEF,
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int QP_W    = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*COEF_W-1:0]  coef_in_flat,
  input  logic [QP_W-1:0]       qp,
  input  logic                  intra,
  output logic [16*LEVEL_W-1:0] level_out_flat,
  output logic                  out_valid,
  output logic                  overrun,
  output logic [4:0]            nz_count
);

  localparam int PROD_W = COEF_W + MF_W;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]             state;
  logic [3:0]             idx;
  logic [16*COEF_W-1:0]   coef_r;
  logic [QP_W-1:0]        qp_r;
  logic                   intra_r;

  logic                   s1_vld;
  logic [3:0]             s1_idx;
  logic                   s1_sign;
  logic [PROD_W-1:0]      s1_prod;

  logic                   accept;
  logic [QP_W-1:0]        qp_clamped;
  logic [2:0]             qp_mod6;
  logic [3:0]             qp_div6;
  logic [4:0]             qbits;
  logic [F_W-1:0]         rnd_f;
  logic signed [COEF_W-1:0] cur_coef;
  logic [COEF_W-1:0]      mag;
  logic [MF_W-1:0]        mf;
  logic [SUM_W-1:0]       sum;
  logic [LEVEL_W-1:0]     lvl_mag;
  logic [LEVEL_W-1:0]     lvl;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  assign qp_clamped = (qp > QP_W'(QP_MAX)) ? QP_W'(QP_MAX) : qp;
  assign qp_mod6    = 3'(qp_r % QP_W'(6));
  assign qp_div6    = 4'(qp_r / QP_W'(6));
  assign qbits      = 5'd15 + 5'(qp_div6);
  assign rnd_f      = round_f(qbits, intra_r);

  // Stage 1 operand: magnitude of the current coefficient; -4096 becomes unsigned 4096
  assign cur_coef = coef_r[idx*COEF_W +: COEF_W];
  assign mag      = cur_coef[COEF_W-1] ? -cur_coef : cur_coef;

  quant_mf_lut u_mf_lut (
    .qp_mod6 (qp_mod6),
    .cls     (pos_class(idx)),
    .mf      (mf)
  );

  // Stage 2 arithmetic: round, shift, restore sign (-0 is still 0 in two's complement)
  assign sum     = SUM_W'(s1_prod) + SUM_W'(rnd_f);
  assign lvl_mag = LEVEL_W'(sum >> qbits);
  assign lvl     = s1_sign ? -lvl_mag : lvl_mag;

  // Control FSM and block capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      coef_r  <= '0;
      qp_r    <= '0;
      intra_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            coef_r  <= coef_in_flat;
            qp_r    <= qp_clamped;
            intra_r <= intra;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: multiply magnitude by MF, carry sign and position along
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_sign <= 1'b0;
      s1_prod <= '0;
    end else begin
      s1_vld  <= (state == ST_RUN);
      s1_idx  <= idx;
      s1_sign <= cur_coef[COEF_W-1];
      s1_prod <= PROD_W'(mag) * PROD_W'(mf);
    end
  end

  // Stage 2: write the level into its slot; old levels persist until overwritten
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_out_flat <= '0;
    end else if (s1_vld) begin
      level_out_flat[s1_idx*LEVEL_W +: LEVEL_W] <= lvl;
    end
  end

  // Sticky flag for blocks offered while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overrun <= 1'b1;
    end
  end

`ifdef QUANT_NZ_COUNT_EN
  logic [4:0] nz_r;

  // Count nonzero levels of the block in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nz_r <= '0;
    end else if (accept) begin
      nz_r <= '0;
    end else if (s1_vld && (lvl != '0)) begin
      nz_r <= nz_r + 5'd1;
    end
  end

  assign nz_count = nz_r;
`else
  assign nz_count = 5'd0;
`endif

endmodule

// File: tb/tb_quant4x4_h264.sv
// Directed bench for quant4x4_h264 with hand-computed expected levels.
// Covers reset, latency and handshake, rounding per mode, extremes, QP clamp, overrun and mid-block reset.
// Each block waits at most 40 cycles for out_valid.
module tb_quant4x4_h264;

  localparam int COEF_W  = 13;
  localparam int LEVEL_W = 12;
  localparam int QP_W    = 6;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [16*COEF_W-1:0]  coef_in_flat = '0;
  logic [QP_W-1:0]       qp = '0;
  logic                  intra = 1'b0;
  logic [16*LEVEL_W-1:0] level_out_flat;
  logic                  out_valid;
  logic                  overrun;
  logic [4:0]            nz_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cin  [16];
  int lexp [16];

  always #5 clk = ~clk;

  quant4x4_h264 #(.COEF_W(COEF_W), .LEVEL_W(LEVEL_W), .QP_W(QP_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .coef_in_flat   (coef_in_flat),
    .qp             (qp),
    .intra          (intra),
    .level_out_flat (level_out_flat),
    .out_valid      (out_valid),
    .overrun        (overrun),
    .nz_count       (nz_count)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) begin
      cin[i]  = 0;
      lexp[i] = 0;
    end
  endtask

  task automatic pack_coefs();
    for (int i = 0; i < 16; i++) coef_in_flat[i*COEF_W +: COEF_W] = COEF_W'(cin[i]);
  endtask

  // mode 0: plain block, 1: extra in_valid at edge T+5, 2: reset pulse from T+8
  task automatic run_block(input string name, input int qp_v, input bit intra_v,
                           input int nz_exp, input int mode);
    int n;
    bit busy_ok;
    bit seen;
    logic [16*LEVEL_W-1:0] got;
    pack_coefs();
    qp       = QP_W'(qp_v);
    intra    = intra_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; busy_ok = 1'b1; seen = 1'b0;
    while (n < 40) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (in_ready && mode != 2) busy_ok = 1'b0;
      if (mode == 1 && n == 4) begin
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) coef_in_flat[i*COEF_W +: COEF_W] = COEF_W'(2000);
      end
      if (mode == 1 && n == 5) begin
        in_valid = 1'b0;
        pack_coefs();
      end
      if (mode == 2 && n == 8) reset_n = 1'b0;
      if (mode == 2 && n == 9) reset_n = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (mode == 2) begin
      check({name, "_no_valid"}, int'(seen), 0);
      check({name, "_in_ready"}, int'(in_ready), 1);
      check({name, "_overrun_clr"}, int'(overrun), 0);
      check({name, "_levels_clr"}, int'(|level_out_flat), 0);
      check({name, "_nz_clr"}, int'(nz_count), 0);
    end else begin
      check({name, "_latency"}, n, 17);
      check({name, "_busy"}, int'(busy_ok), 1);
      got = level_out_flat;
`ifdef QUANT_NZ_COUNT_EN
      check({name, "_nz"}, int'(nz_count), nz_exp);
`else
      check({name, "_nz"}, int'(nz_count), 0 * nz_exp);
`endif
      for (int i = 0; i < 16; i++) begin
        logic [LEVEL_W-1:0] l;
        l = got[i*LEVEL_W +: LEVEL_W];
        check($sformatf("%s_lvl%0d", name, i), int'($signed(l)), lexp[i]);
      end
      @(posedge clk); #1;
      check({name, "_valid_pulse"}, int'(out_valid), 0);
      check({name, "_ready_back"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_levels", int'(|level_out_flat), 0);
    check("rst_nz", int'(nz_count), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    clear_vec();
    run_block("zero", 28, 1'b1, 0, 0);

    clear_vec();
    cin[0] = 100; lexp[0] = 40;
    run_block("dc100", 0, 1'b1, 1, 0);
    check("overrun_still_0", int'(overrun), 0);

    clear_vec();
    cin[5] = -200; lexp[5] = -16;
    run_block("inter_b", 6, 1'b0, 1, 0);

    clear_vec();
    cin[0] = -4096; cin[1] = -4096; lexp[0] = -1638; lexp[1] = -1008;
    run_block("minval", 0, 1'b1, 2, 0);

    clear_vec();
    cin[0] = 4095; lexp[0] = 4;
    run_block("qpclamp", 60, 1'b1, 1, 0);

    clear_vec();
    cin[0] = 100; lexp[0] = 40;
    run_block("overrun", 0, 1'b1, 1, 1);
    check("overrun_set", int'(overrun), 1);

    clear_vec();
    cin[5] = -200;
    run_block("abort", 6, 1'b0, 1, 2);

    clear_vec();
    cin[0] = -4096; cin[1] = -4096; lexp[0] = -1638; lexp[1] = -1008;
    run_block("after_abort", 0, 1'b1, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/quant4x4_h264.md
Name: quant4x4_h264

Overview:
- Forward quantizer for H.264 4x4 integer-transform coefficients, directly downstream of the 4x4 DCT stage.
- Accepts one flat 16-coefficient block (13-bit signed each) plus QP and intra/inter mode, and quantizes one coefficient per cycle through a 2-stage multiply/round pipeline.
- Presents the 16 quantized levels as one flat word with a one-cycle valid pulse, ready for the zigzag/CAVLC stage.

Parameters:
- COEF_W, 13, signed input coefficient width.
- LEVEL_W, 12, signed output level width.
- QP_W, 6, QP input width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  block present on coef_in_flat; connects to the DCT valid.
- in_ready  out  1  high only in IDLE.
- coef_in_flat  in  16*COEF_W  coefficient i=row*4+col at bits [i*COEF_W +: COEF_W]; row 0 in the LSBs.
- qp  in  QP_W  quantization parameter, sampled on accept.
- intra  in  1  1 = intra rounding, 0 = inter rounding; sampled on accept.
- level_out_flat  out  16*LEVEL_W  same packing as the input.
- out_valid  out  1  one-cycle pulse.
- overrun  out  1  sticky: a block arrived while busy.
- nz_count  out  5  nonzero level count (optional feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, overrun=0, level_out_flat=0, nz_count=0, pipeline regs=0.
- Accept: at a clk edge T with in_valid && in_ready, capture coef_in_flat, qp and intra. QP>51 is clamped to 51.
- States:
  - IDLE: on accept, go to RUN with idx=0.
  - RUN: idx 0..15, one coefficient per cycle; after idx 15, go to FLUSH.
  - FLUSH: 1 cycle, then DONE.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- Stage 1 (edge T+k, k=1..16): prod = |coef[k-1]| * MF; register the sign and position class.
- Stage 2 (edge T+k+1): level = (prod + f) >> qbits, with the sign restored; write it into level_out_flat[k-1].
  - The last level is written at T+17.
  - out_valid is high for the cycle following edge T+17.
  - in_ready returns high at T+18.
- MF by (qp%6, class):
  - Class a: (row,col) both even. Class b: both odd. Class c: otherwise.
  - qp%6=0: 13107, 5243, 8066
  - qp%6=1: 11916, 4660, 7490
  - qp%6=2: 10082, 4194, 6554
  - qp%6=3: 9362, 3647, 5825
  - qp%6=4: 8192, 3355, 5243
  - qp%6=5: 7282, 2893, 4559
- Rounding: qbits = 15 + qp/6. f = floor(2^qbits/3) for intra, floor(2^qbits/6) for inter.
- Arithmetic widths: magnitude 13-bit unsigned (-4096 maps to 4096); product 27 bits; sum 28 bits. The worst case is |level|=1638, which fits LEVEL_W, so no saturation is needed.
- Zero input gives level 0 with no negative zero.
- level_out_flat holds its value until the next block's first write. Levels are overwritten progressively during the next block, so consumers must latch on out_valid.
- in_valid while in_ready=0: ignored and overrun set to 1 (sticky until reset). The current block is unaffected.
- reset_n asserted mid-block: abort immediately to the reset values; no out_valid for the aborted block.

Optional Feature:
- QUANT_NZ_COUNT_EN defined: nz_count is cleared at accept, incremented in stage 2 for each nonzero level, and valid alongside out_valid (range 0..16).
- Undefined: nz_count is tied to 0 and no counter logic is built.

Decomposition:
- Package quant_h264_pkg: COEF_W/LEVEL_W defaults, the 6x3 MF constant table, QP_MAX=51, the position-class encoding typedef (CLS_A/B/C), and functions pos_class(idx) and round_f(qbits,intra).
- Sub-module quant_mf_lut: combinational (qp_mod6, class) -> MF, reusable by the dequantizer.

Test Plan:
- All coefficients 0, qp=28, intra -> all levels 0; out_valid exactly one cycle after edge T+17; in_ready low during T..T+17.
- coef[0]=100, others 0, qp=0, intra -> level[0]=40, others 0; nz_count=1 when enabled.
- coef[5]=-200, qp=6, inter (MF 5243, qbits 16, f=10922) -> level[5]=-16.
- coef[0]=-4096 and coef[1]=-4096, qp=0, intra -> level[0]=-1638, level[1]=-1008.
- coef[0]=4095, qp=60 (clamped to 51, MF 9362, qbits 23) -> level[0]=4.
- Second in_valid at T+5 -> ignored, overrun=1, first block's results unchanged. Separately, reset_n low at T+8 -> out_valid never pulses; in_ready=1 after release; the next block quantizes correctly.
